// File: rtl/arm_multicycle_controller_if.sv
// Bus between the multicycle ARM controller and its datapath.
// The controller takes the master side, the datapath the slave side.
interface arm_multicycle_controller_if;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUControl;
    logic        MovFlag;
    logic [3:0]  State;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, ALUControl, MovFlag, State
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, ALUControl, MovFlag, State
    );
endinterface

// File: rtl/arm_multicycle_controller.sv
// Multicycle ARMv4-subset control FSM with NZCV flags and condition gating.
// Define ARM_MC_MOV_EN to accept MOV (Funct[4:1]=1101); otherwise it is unimplemented.
module arm_multicycle_controller (
    input  logic                               clk,
    input  logic                               reset,
    arm_multicycle_controller_if.master        bus
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7, ALUWB = 4'd8,
        BRANCH = 4'd9, UNKNOWN = 4'd10
    } state_t;

    typedef struct packed {
        logic       pc_fetch;
        logic       pc_cond;
        logic       mem_write;
        logic       reg_write;
        logic       ir_write;
        logic       adr_src;
        logic [1:0] reg_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic [1:0] alu_control;
        logic       mov_flag;
    } ctl_t;

    state_t     state_reg, state_next, ctl_state;
    logic [3:0] flags_reg;
    logic       cond_ex_reg, cond_ex_next, ctl_cx, cond_pass;
    ctl_t       ctl_reg, ctl_next;
    logic [1:0] dp_control;
    logic       dp_legal, dp_arith, dp_mov;
    logic       unused_instr_bits;

    wire [3:0] cond   = bus.Instr[31:28];
    wire [1:0] op     = bus.Instr[27:26];
    wire       imm_op = bus.Instr[25];
    wire [3:0] funct  = bus.Instr[24:21];
    wire       s_bit  = bus.Instr[20];
    wire       rd_pc  = (bus.Instr[15:12] == 4'hF);
    wire n_flag = flags_reg[3];
    wire z_flag = flags_reg[2];
    wire c_flag = flags_reg[1];
    wire v_flag = flags_reg[0];

    assign unused_instr_bits = ^{bus.Instr[19:16], bus.Instr[11:0]};

    always_comb begin
        case (cond)
            4'h0:    cond_pass = z_flag;
            4'h1:    cond_pass = ~z_flag;
            4'h2:    cond_pass = c_flag;
            4'h3:    cond_pass = ~c_flag;
            4'h4:    cond_pass = n_flag;
            4'h5:    cond_pass = ~n_flag;
            4'h6:    cond_pass = v_flag;
            4'h7:    cond_pass = ~v_flag;
            4'h8:    cond_pass = c_flag & ~z_flag;
            4'h9:    cond_pass = ~c_flag | z_flag;
            4'hA:    cond_pass = (n_flag == v_flag);
            4'hB:    cond_pass = (n_flag != v_flag);
            4'hC:    cond_pass = ~z_flag & (n_flag == v_flag);
            4'hD:    cond_pass = z_flag | (n_flag != v_flag);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        dp_control = 2'b00;
        dp_legal   = 1'b0;
        dp_arith   = 1'b0;
        dp_mov     = 1'b0;
        case (funct)
            4'b0100: begin dp_control = 2'b00; dp_legal = 1'b1; dp_arith = 1'b1; end
            4'b0010: begin dp_control = 2'b01; dp_legal = 1'b1; dp_arith = 1'b1; end
            4'b0000: begin dp_control = 2'b10; dp_legal = 1'b1; end
            4'b1100: begin dp_control = 2'b11; dp_legal = 1'b1; end
`ifdef ARM_MC_MOV_EN
            4'b1101: begin dp_control = 2'b11; dp_legal = 1'b1; dp_mov = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:    state_next = DECODE;
            DECODE: begin
                case (op)
                    2'b00:   state_next = imm_op ? EXECUTEI : EXECUTER;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = UNKNOWN;
                endcase
            end
            MEMADR:   state_next = s_bit ? MEMRD : MEMWR;
            MEMRD:    state_next = MEMWB;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            default:  state_next = FETCH;
        endcase
    end

    assign cond_ex_next = (state_reg == DECODE) ? cond_pass : cond_ex_reg;

    // Outputs are registered, so they are decoded from the state being entered.
    assign ctl_state = reset ? state_next : FETCH;
    assign ctl_cx    = reset ? cond_ex_next : 1'b0;

    always_comb begin
        ctl_next = '0;
        case (ctl_state)
            FETCH: begin
                ctl_next.pc_fetch   = 1'b1;
                ctl_next.ir_write   = 1'b1;
                ctl_next.alu_src_a  = 1'b1;
                ctl_next.alu_src_b  = 2'b10;
                ctl_next.result_src = 2'b10;
            end
            DECODE: begin
                ctl_next.alu_src_a  = 1'b1;
                ctl_next.alu_src_b  = 2'b10;
                ctl_next.result_src = 2'b10;
            end
            MEMADR: begin
                ctl_next.alu_src_b = 2'b01;
                ctl_next.imm_src   = 2'b01;
            end
            MEMRD:  ctl_next.adr_src = 1'b1;
            MEMWB: begin
                ctl_next.result_src = 2'b01;
                ctl_next.reg_write  = ctl_cx & ~rd_pc;
                ctl_next.pc_cond    = ctl_cx & rd_pc;
            end
            MEMWR: begin
                ctl_next.adr_src   = 1'b1;
                ctl_next.reg_src   = 2'b10;
                ctl_next.mem_write = ctl_cx;
            end
            EXECUTER, EXECUTEI: begin
                ctl_next.alu_src_b   = (ctl_state == EXECUTEI) ? 2'b01 : 2'b00;
                ctl_next.alu_control = dp_control;
                ctl_next.mov_flag    = dp_mov & ctl_cx;
            end
            ALUWB: begin
                ctl_next.reg_write = ctl_cx & dp_legal & ~rd_pc;
                ctl_next.pc_cond   = ctl_cx & dp_legal & rd_pc;
                ctl_next.mov_flag  = dp_mov & ctl_cx;
            end
            BRANCH: begin
                ctl_next.alu_src_b  = 2'b01;
                ctl_next.imm_src    = 2'b10;
                ctl_next.result_src = 2'b10;
                ctl_next.reg_src    = 2'b01;
                ctl_next.pc_cond    = ctl_cx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        ctl_reg <= ctl_next;
        if (!reset) begin
            state_reg   <= FETCH;
            flags_reg   <= 4'b0000;
            cond_ex_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cond_ex_reg <= cond_ex_next;
            if ((state_reg == EXECUTER || state_reg == EXECUTEI) && s_bit && cond_ex_reg) begin
                flags_reg[3:2] <= bus.ALUFlags[3:2];
                if (dp_arith)
                    flags_reg[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

    // Reset asserted mid-instruction masks the pending architectural write at once.
    assign bus.PCWrite    = ctl_reg.pc_fetch | (ctl_reg.pc_cond & reset);
    assign bus.MemWrite   = ctl_reg.mem_write & reset;
    assign bus.RegWrite   = ctl_reg.reg_write & reset;
    assign bus.IRWrite    = ctl_reg.ir_write;
    assign bus.AdrSrc     = ctl_reg.adr_src;
    assign bus.RegSrc     = ctl_reg.reg_src;
    assign bus.ALUSrcA    = ctl_reg.alu_src_a;
    assign bus.ALUSrcB    = ctl_reg.alu_src_b;
    assign bus.ResultSrc  = ctl_reg.result_src;
    assign bus.ImmSrc     = ctl_reg.imm_src;
    assign bus.ALUControl = ctl_reg.alu_control;
    assign bus.MovFlag    = ctl_reg.mov_flag;
    assign bus.State      = state_reg;
endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Bench for arm_multicycle_controller: directed instruction table, reset corner
// cases, then random instructions checked cycle by cycle against a reference model.
module tb_arm_multicycle_controller;
`ifdef ARM_MC_MOV_EN
    localparam bit MOV_EN = 1'b1;
`else
    localparam bit MOV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    arm_multicycle_controller_if bus();

    arm_multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference flags (N,Z,C,V)
    bit mn, mz, mc, mv;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  flags;
        int          cycles;
        int          regw;
        int          memw;
        int          pcw;
        int          mov;
        string       name;
    } vec_t;

    typedef struct {
        logic [20:0] v;
        bit          exec;
    } step_t;

    step_t plan[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] outs();
        return {bus.State, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc,
                bus.RegSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc,
                bus.ALUControl, bus.MovFlag};
    endfunction

    function automatic logic [20:0] vec(input logic [3:0] st, input bit pcw, input bit memw,
                                        input bit regw, input bit irw, input bit adr,
                                        input logic [1:0] rsrc, input bit srca,
                                        input logic [1:0] srcb, input logic [1:0] res,
                                        input logic [1:0] imm, input logic [1:0] aluc,
                                        input bit mov);
        return {st, pcw, memw, regw, irw, adr, rsrc, srca, srcb, res, imm, aluc, mov};
    endfunction

    // ARM condition: even code = base test, odd code = its inverse; AL true, 1111 false.
    function automatic bit cond_ok(input logic [3:0] c);
        bit base;
        case (c[3:1])
            3'd0:    base = mz;
            3'd1:    base = mc;
            3'd2:    base = mn;
            3'd3:    base = mv;
            3'd4:    base = mc && !mz;
            3'd5:    base = (mn == mv);
            3'd6:    base = !mz && (mn == mv);
            default: return (c == 4'hE);
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic build_plan(input logic [31:0] ins, input bit cx);
        logic [3:0] f;
        bit rd15, legal, mov;
        logic [1:0] aluc;
        f     = ins[24:21];
        rd15  = (ins[15:12] == 4'hF);
        mov   = MOV_EN && (f == 4'b1101);
        legal = (f == 4'b0100) || (f == 4'b0010) || (f == 4'b0000) || (f == 4'b1100) || mov;
        aluc  = (f == 4'b0010) ? 2'd1 : (f == 4'b0000) ? 2'd2 :
                ((f == 4'b1100) || mov) ? 2'd3 : 2'd0;
        plan.delete();
        plan.push_back('{vec(4'd0, 1, 0, 0, 1, 0, 2'd0, 1, 2'd2, 2'd2, 2'd0, 2'd0, 0), 1'b0});
        plan.push_back('{vec(4'd1, 0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 2'd2, 2'd0, 2'd0, 0), 1'b0});
        case (ins[27:26])
            2'b00: begin
                plan.push_back('{vec(ins[25] ? 4'd7 : 4'd6, 0, 0, 0, 0, 0, 2'd0, 0,
                                     ins[25] ? 2'd1 : 2'd0, 2'd0, 2'd0, aluc, mov && cx), 1'b1});
                plan.push_back('{vec(4'd8, legal && cx && rd15, 0, legal && cx && !rd15, 0, 0,
                                     2'd0, 0, 2'd0, 2'd0, 2'd0, 2'd0, mov && cx), 1'b0});
            end
            2'b01: begin
                plan.push_back('{vec(4'd2, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, 2'd1, 2'd0, 0), 1'b0});
                if (ins[20]) begin
                    plan.push_back('{vec(4'd3, 0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0), 1'b0});
                    plan.push_back('{vec(4'd4, cx && rd15, 0, cx && !rd15, 0, 0, 2'd0, 0, 2'd0,
                                         2'd1, 2'd0, 2'd0, 0), 1'b0});
                end else begin
                    plan.push_back('{vec(4'd5, 0, cx, 0, 0, 1, 2'd2, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0), 1'b0});
                end
            end
            2'b10: plan.push_back('{vec(4'd9, cx, 0, 0, 0, 0, 2'd1, 0, 2'd1, 2'd2, 2'd2, 2'd0, 0), 1'b0});
            default: plan.push_back('{vec(4'd10, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0), 1'b0});
        endcase
    endtask

    // Runs one instruction from its FETCH cycle, counting strobes per cycle.
    task automatic run_counts(input vec_t t);
        int n, rw, mw, pw, mf;
        n = 0; rw = 0; mw = 0; pw = 0; mf = 0;
        do begin
            if (n == 1) bus.Instr = t.instr;
            bus.ALUFlags = t.flags;
            if (n > 0 && bus.PCWrite) pw++;
            if (bus.RegWrite) rw++;
            if (bus.MemWrite) mw++;
            if (bus.MovFlag) mf++;
            @(posedge clk); #1;
            n++;
        end while (bus.State != 4'd0 && n < 12);
        check({t.name, " cycles"}, n, t.cycles);
        check({t.name, " regwrite"}, rw, t.regw);
        check({t.name, " memwrite"}, mw, t.memw);
        check({t.name, " pcwrite"}, pw, t.pcw);
        check({t.name, " movflag"}, mf, t.mov);
        $display("instr %08h %s cycles=%0d regw=%0d memw=%0d pcw=%0d mov=%0d",
                 t.instr, t.name, n, rw, mw, pw, mf);
    endtask

    task automatic run_model(input logic [31:0] ins);
        bit cx;
        logic [3:0] af;
        cx = cond_ok(ins[31:28]);
        build_plan(ins, cx);
        for (int i = 0; i < plan.size(); i++) begin
            if (i == 1) bus.Instr = ins;
            af = 4'($urandom);
            bus.ALUFlags = af;
            check($sformatf("step%0d", i), {11'd0, outs()}, {11'd0, plan[i].v});
            if (plan[i].exec && ins[20] && cx) begin
                mn = af[3];
                mz = af[2];
                if (ins[24:21] == 4'b0100 || ins[24:21] == 4'b0010) begin
                    mc = af[1];
                    mv = af[0];
                end
            end
            @(posedge clk); #1;
        end
        $display("instr %08h cond_pass=%0d steps=%0d flags=%b%b%b%b",
                 ins, cx, plan.size(), mn, mz, mc, mv);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [3:0] c, f;
        int cls, k;
        c   = ($urandom_range(0, 9) < 6) ? 4'hE : 4'($urandom);
        cls = $urandom_range(0, 9);
        if (cls < 5) begin
            k = $urandom_range(0, 5);
            f = (k == 0) ? 4'b0100 : (k == 1) ? 4'b0010 : (k == 2) ? 4'b0000 :
                (k == 3) ? 4'b1100 : (k == 4) ? 4'b1101 : 4'($urandom);
            return {c, 2'b00, 1'($urandom), f, 1'($urandom), 4'($urandom),
                    ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom), 12'($urandom)};
        end else if (cls < 7) begin
            return {c, 2'b01, 6'($urandom), 4'($urandom),
                    ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom), 12'($urandom)};
        end else if (cls < 9) begin
            return {c, 2'b10, 26'($urandom)};
        end
        return {c, 2'b11, 26'($urandom)};
    endfunction

    vec_t tbl[$];
    int   wait_n;

    initial begin
        bus.Instr    = 32'h0;
        bus.ALUFlags = 4'h0;

        tbl.push_back('{32'h0A000002, 4'hF, 3, 0, 0, 0, 0, "BEQ after reset"});
        tbl.push_back('{32'h1A000002, 4'hF, 3, 0, 0, 1, 0, "BNE after reset"});
        tbl.push_back('{32'hE2802005, 4'h0, 4, 1, 0, 0, 0, "ADD R2,R0,#5"});
        tbl.push_back('{32'hE5902060, 4'h0, 5, 1, 0, 0, 0, "LDR R2"});
        tbl.push_back('{32'hE5802064, 4'h0, 4, 0, 1, 0, 0, "STR R2"});
        tbl.push_back('{32'hE0500000, 4'h6, 4, 1, 0, 0, 0, "SUBS Z=1"});
        tbl.push_back('{32'h0A000002, 4'h0, 3, 0, 0, 1, 0, "BEQ taken"});
        tbl.push_back('{32'h1A000002, 4'h0, 3, 0, 0, 0, 0, "BNE not taken"});
        tbl.push_back('{32'hE0500000, 4'h0, 4, 1, 0, 0, 0, "SUBS Z=0"});
        tbl.push_back('{32'h00911001, 4'h4, 4, 0, 0, 0, 0, "ADDEQS fail"});
        tbl.push_back('{32'h0A000002, 4'h4, 3, 0, 0, 0, 0, "BEQ flags kept"});
        tbl.push_back('{32'hE590F000, 4'h0, 5, 0, 0, 1, 0, "LDR PC"});
        tbl.push_back('{32'hE0211002, 4'h0, 4, 0, 0, 0, 0, "EOR unimpl"});
        tbl.push_back('{32'hEC000000, 4'h0, 3, 0, 0, 0, 0, "UNKNOWN op"});
        tbl.push_back('{32'hE3A01007, 4'h0, 4, MOV_EN ? 1 : 0, 0, 0, MOV_EN ? 2 : 0, "MOV R1,#7"});
        tbl.push_back('{32'h05802064, 4'h0, 4, 0, 0, 0, 0, "STREQ fail"});
        tbl.push_back('{32'hEA000000, 4'h0, 3, 0, 0, 1, 0, "BAL"});
        tbl.push_back('{32'hFA000000, 4'h0, 3, 0, 0, 0, 0, "B cond 1111"});
        tbl.push_back('{32'hE081F002, 4'h0, 4, 0, 0, 1, 0, "ADD PC"});

        // Reset held low two cycles, then released in the first FETCH cycle
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("reset state", {28'd0, bus.State}, 32'd0);
        check("reset pcwrite", {31'd0, bus.PCWrite}, 32'd1);
        check("reset irwrite", {31'd0, bus.IRWrite}, 32'd1);
        check("reset regwrite", {31'd0, bus.RegWrite}, 32'd0);
        check("reset memwrite", {31'd0, bus.MemWrite}, 32'd0);

        foreach (tbl[i]) run_counts(tbl[i]);

        // Reset arriving during MEMWR kills the store in that same cycle
        wait_n = 0;
        do begin
            if (wait_n == 1) bus.Instr = 32'hE5802064;
            @(posedge clk); #1;
            wait_n++;
        end while (bus.State != 4'd5 && wait_n < 8);
        check("reach MEMWR", {28'd0, bus.State}, 32'd5);
        check("MEMWR memwrite", {31'd0, bus.MemWrite}, 32'd1);
        reset = 1'b0;
        #1;
        check("reset in MEMWR memwrite", {31'd0, bus.MemWrite}, 32'd0);
        @(posedge clk); #1;
        check("after reset state", {28'd0, bus.State}, 32'd0);
        check("after reset memwrite", {31'd0, bus.MemWrite}, 32'd0);
        reset = 1'b1;
        $display("reset during MEMWR state=%0d memwrite=%0d", bus.State, bus.MemWrite);

        mn = 0; mz = 0; mc = 0; mv = 0;
        for (int i = 0; i < 250; i++) run_model(rand_instr());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
